// File: rtl/decode_stage_hz_if.sv
// Bundle between IF/ID + write-back and the decode stage's ID/EX outputs.
// The DUT takes the slave side; the upstream/downstream environment takes master.
interface decode_stage_hz_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned ALUOP_W = 6
);
  logic               in_valid;
  logic [31:0]        instruccion;
  logic               reg_write_in;
  logic [REG_AW-1:0]  WR;
  logic [DATA_W-1:0]  WD;
  logic               flush;
  logic               stall;
  logic               out_valid;
  logic [DATA_W-1:0]  data1;
  logic [DATA_W-1:0]  data2;
  logic [DATA_W-1:0]  ext_sig;
  logic [REG_AW-1:0]  rs;
  logic [REG_AW-1:0]  rt;
  logic [REG_AW-1:0]  rd;
  logic               branch;
  logic               mem_read;
  logic               mem_write;
  logic               mem_to_reg;
  logic               reg_dst;
  logic               reg_write_out;
  logic               alu_src;
  logic [ALUOP_W-1:0] alu_op;

  modport master (
    output in_valid, instruccion, reg_write_in, WR, WD, flush,
    input  stall, out_valid, data1, data2, ext_sig, rs, rt, rd, branch, mem_read,
           mem_write, mem_to_reg, reg_dst, reg_write_out, alu_src, alu_op
  );

  modport slave (
    input  in_valid, instruccion, reg_write_in, WR, WD, flush,
    output stall, out_valid, data1, data2, ext_sig, rs, rt, rd, branch, mem_read,
           mem_write, mem_to_reg, reg_dst, reg_write_out, alu_src, alu_op
  );
endinterface

// File: rtl/decode_stage_hz.sv
// Decode stage: bypassed register bank, sign extension, control decode, load-use
// hazard detection, and the ID/EX pipeline register with stall/flush bubbles.
module decode_stage_hz #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned ALUOP_W = 6
) (
  input logic             clk,
  input logic             rst,
  decode_stage_hz_if.slave io_bus
);
  localparam int unsigned NumRegs = 2 ** REG_AW;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;

  logic [DATA_W-1:0]  r_bank [NumRegs];

  logic               r_out_valid;
  logic [DATA_W-1:0]  r_data1, r_data2, r_ext_sig;
  logic [REG_AW-1:0]  r_rs, r_rt, r_rd;
  logic [6:0]         r_ctrl;  // {branch, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src}
  logic [ALUOP_W-1:0] r_alu_op;

  logic [5:0]         w_opcode;
  logic [REG_AW-1:0]  w_rs, w_rt, w_rd;
  logic [DATA_W-1:0]  w_ext, w_data1, w_data2;
  logic [ALUOP_W-1:0] w_alu_op;
  logic [6:0]         w_ctrl;
  logic               w_uses_rt, w_wr_en, w_stall;

  assign w_opcode = io_bus.instruccion[31:26];
  assign w_rs     = REG_AW'(io_bus.instruccion[25:21]);
  assign w_rt     = REG_AW'(io_bus.instruccion[20:16]);
  assign w_rd     = REG_AW'(io_bus.instruccion[15:11]);
  assign w_ext    = {{(DATA_W-16){io_bus.instruccion[15]}}, io_bus.instruccion[15:0]};
  assign w_alu_op = (w_opcode == OpRtype) ? ALUOP_W'(io_bus.instruccion[5:0])
                                          : ALUOP_W'(w_opcode);
  assign w_wr_en  = io_bus.reg_write_in && (io_bus.WR != '0);

  // Write-through: a same-cycle write-back to the read index wins over the bank.
  always_comb begin
    w_data1 = r_bank[w_rs];
    if (w_rs == '0)                           w_data1 = '0;
    else if (w_wr_en && (io_bus.WR == w_rs))  w_data1 = io_bus.WD;
    w_data2 = r_bank[w_rt];
    if (w_rt == '0)                           w_data2 = '0;
    else if (w_wr_en && (io_bus.WR == w_rt))  w_data2 = io_bus.WD;
  end

  always_comb begin
    w_ctrl    = 7'b0;
    w_uses_rt = 1'b0;
    case (w_opcode)
      OpRtype: begin w_ctrl = 7'b0000110; w_uses_rt = 1'b1; end
      OpLw:          w_ctrl = 7'b0101011;
      OpSw:    begin w_ctrl = 7'b0010001; w_uses_rt = 1'b1; end
      OpBeq:   begin w_ctrl = 7'b1000000; w_uses_rt = 1'b1; end
      OpAddi:        w_ctrl = 7'b0000011;
      default:       w_ctrl = 7'b0;
    endcase
  end

  // r_ctrl[5] is the EX-stage mem_read.
  assign w_stall = io_bus.in_valid && r_out_valid && r_ctrl[5] && (r_rt != '0) &&
                   ((r_rt == w_rs) || (w_uses_rt && (r_rt == w_rt))) && !io_bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NumRegs; i++) r_bank[i] <= '0;
    end else if (w_wr_en) begin
      r_bank[io_bus.WR] <= io_bus.WD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || io_bus.flush || w_stall) begin
      r_out_valid <= 1'b0;
      r_data1     <= '0;
      r_data2     <= '0;
      r_ext_sig   <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_ctrl      <= '0;
      r_alu_op    <= '0;
    end else begin
      r_out_valid <= io_bus.in_valid;
      r_data1     <= w_data1;
      r_data2     <= w_data2;
      r_ext_sig   <= w_ext;
      r_rs        <= w_rs;
      r_rt        <= w_rt;
      r_rd        <= w_rd;
      r_ctrl      <= io_bus.in_valid ? w_ctrl : 7'b0;
      r_alu_op    <= w_alu_op;
    end
  end

  assign io_bus.stall         = w_stall;
  assign io_bus.out_valid     = r_out_valid;
  assign io_bus.data1         = r_data1;
  assign io_bus.data2         = r_data2;
  assign io_bus.ext_sig       = r_ext_sig;
  assign io_bus.rs            = r_rs;
  assign io_bus.rt            = r_rt;
  assign io_bus.rd            = r_rd;
  assign io_bus.branch        = r_ctrl[6];
  assign io_bus.mem_read      = r_ctrl[5];
  assign io_bus.mem_write     = r_ctrl[4];
  assign io_bus.mem_to_reg    = r_ctrl[3];
  assign io_bus.reg_dst       = r_ctrl[2];
  assign io_bus.reg_write_out = r_ctrl[1];
  assign io_bus.alu_src       = r_ctrl[0];
  assign io_bus.alu_op        = r_alu_op;
endmodule
